regfile_write_queue: RTL and testbench
======================================

Name: regfile_write_queue

Overview:
- Buffers register-file write requests upstream of the register file's write port.
- Accepts (addr, data) pairs on a valid/ready handshake and drains them in order to the regfile write port, one per cycle when the port is ready.
- Provides a combinational lookup so the read path can forward data that is still queued and not yet committed.
- Downstream is the write-enabled regfile variant; out_valid is its write enable.

Parameters:
- ADDR_WIDTH, 2, regfile address width (regfile has 2**ADDR_WIDTH entries).
- DATA_WIDTH, 4, regfile data width.
- DEPTH, 4, queue entries; power of two, >= 2.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESETN  in  1  reset, synchronous, active-low; sampled on the CLK rising edge.
- in_valid  in  1  write request present.
- in_ready  out  1  queue can accept a request; equals ~full.
- in_addr  in  ADDR_WIDTH  request address.
- in_data  in  DATA_WIDTH  request data.
- out_valid  out  1  head entry valid; regfile write enable.
- out_ready  in  1  regfile accepts the write this cycle.
- out_addr  out  ADDR_WIDTH  head entry address.
- out_data  out  DATA_WIDTH  head entry data.
- lookup_addr  in  ADDR_WIDTH  read-path address to check.
- lookup_hit  out  1  some queued entry targets lookup_addr.
- lookup_data  out  DATA_WIDTH  data of youngest matching entry; 0 when no hit.
- count  out  clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Storage:
  - DEPTH entries of {addr, data} plus one valid bit per entry.
  - wr_ptr and rd_ptr are clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is held as a separate register.
- Push: in_valid & in_ready at edge N.
  - entry[wr_ptr] is written and marked valid; wr_ptr increments.
  - The entry is visible on out_* and to lookup from cycle N+1; there is no fall-through.
- Pop: out_valid & out_ready at edge N.
  - entry[rd_ptr] is invalidated; rd_ptr increments.
  - The next entry appears on out_* in cycle N+1.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When full, in_ready is still 0, even if a pop occurs in the same cycle; there is no pop-through.
  - When empty, a push proceeds normally; the pushed entry cannot pop in the same cycle.
- Status:
  - full = (count == DEPTH); empty = (count == 0).
  - out_valid = ~empty.
  - out_addr and out_data come combinationally from the head entry.
- count updates: +1 on push only, -1 on pop only, unchanged otherwise. It never exceeds DEPTH and never underflows.
- in_valid while full: the request is not accepted and state is unchanged. Upstream must hold the request stable until in_ready.
- out_ready while empty: no effect.
- Lookup (purely combinational):
  - Compares lookup_addr against every valid entry.
  - Among matches, the youngest wins, i.e. the closest preceding wr_ptr in age order.
  - The head entry also counts if it is valid and matching, including in the cycle it is being popped. The caller merges this result with regfile read data.
- Reset (RESETN == 0 at an edge):
  - wr_ptr, rd_ptr, count and all valid bits go to 0.
  - Outputs then read: out_valid 0, in_ready 1, lookup_hit 0, lookup_data 0, count 0.
  - Entry payload registers are not reset; they are don't-care while invalid.
  - out_addr and out_data are don't-care while out_valid is 0.
- Reset mid-operation: all queued writes are discarded and none reach the regfile. Reset has priority over a push or pop in the same edge.

Decomposition:
- Shared package:
  - ADDR_WIDTH and DATA_WIDTH defaults.
  - Entry typedef {addr, data}.
  - PTR_WIDTH and CNT_WIDTH derived from DEPTH.
- One sub-module, regfile_wq_lookup:
  - Inputs: the entry array, the valid vector, wr_ptr and lookup_addr.
  - Outputs: hit and data, via an age-ordered priority select.
  - Kept separate so it can be reused for a second read port.

Test Plan:
- Reset then idle: RESETN=0 for 2 cycles then 1 -> out_valid=0, in_ready=1, count=0, lookup_hit=0, lookup_data=0.
- Fill and drain in order: with out_ready=0, push (1,0xA), (2,0xB), (3,0xC), (0,0xD); then out_ready=1 for 4 cycles.
  - During the fill: count=4, in_ready=0.
  - During the drain, out_* shows (1,0xA), (2,0xB), (3,0xC), (0,0xD) on successive cycles; then out_valid=0.
- Full with simultaneous push and pop: with count=4, set in_valid=1 (3,0x7) and out_ready=1 -> the pop occurs, the push is rejected (in_ready=0), count=3. Next cycle the push is accepted and count=4.
- Youngest-match forwarding: push (2,0x5) then (2,0x9), hold out_ready=0, lookup_addr=2 -> hit=1, data=0x9. Pop once -> data=0x9. Pop again -> hit=0, data=0.
- Pointer wrap-around: stream 10 pushes with out_ready=1 continuously -> every entry is written out exactly once, in order, and count never exceeds 2.
- Reset mid-operation: with 3 entries queued, pulse RESETN=0 for 1 cycle while in_valid=1 -> count=0, out_valid=0, no write is issued, and the pushed request is not captured.

Source files
------------

// File: rtl/regfile_write_queue_pkg.sv
// Shared widths and entry type for the regfile write queue and its lookup port.
package regfile_write_queue_pkg;

  localparam int WQ_ADDR_WIDTH = 2;
  localparam int WQ_DATA_WIDTH = 4;
  localparam int WQ_DEPTH      = 4;
  localparam int WQ_PTR_WIDTH  = $clog2(WQ_DEPTH);
  localparam int WQ_CNT_WIDTH  = WQ_PTR_WIDTH + 1;

  typedef struct packed {
    logic [WQ_ADDR_WIDTH-1:0] addr;
    logic [WQ_DATA_WIDTH-1:0] data;
  } entry_t;

endpackage

// File: rtl/regfile_wq_lookup.sv
// Age-ordered forwarding lookup over the write-queue entries; youngest match wins.
module regfile_wq_lookup #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_addr,
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data,
  input  logic [DEPTH-1:0]                 ent_valid,
  input  logic [PTR_W-1:0]                 wr_ptr,
  input  logic [ADDR_WIDTH-1:0]            lookup_addr,
  output logic                             hit,
  output logic [DATA_WIDTH-1:0]            data
);

  logic [PTR_W-1:0] idx;

  // Walk from oldest (wr_ptr) to youngest (wr_ptr-1) so later matches override.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx = wr_ptr - PTR_W'(k) - PTR_W'(1);
      if (ent_valid[idx] && ent_addr[idx] == lookup_addr) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_write_queue.sv
// In-order write buffer in front of the regfile write port, with read-path forwarding.
module regfile_write_queue
  import regfile_write_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = WQ_ADDR_WIDTH,
  parameter int DATA_WIDTH = WQ_DATA_WIDTH,
  parameter int DEPTH      = WQ_DEPTH,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  lookup_hit,
  output logic [DATA_WIDTH-1:0] lookup_data,
  output logic [CNT_W-1:0]      count
);

  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]                 valid_q, valid_d;
  logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                 count_q, count_d;
  logic                             full, empty, push, pop;

  always_comb begin
    full     = (count_q == CNT_W'(DEPTH));
    empty    = (count_q == '0);
    push     = in_valid & ~full;
    pop      = out_ready & ~empty;
    addr_d   = addr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // push and pop never target the same slot: push needs ~full, pop needs ~empty.
    if (push) begin
      addr_d[wr_ptr_q]  = in_addr;
      data_d[wr_ptr_q]  = in_data;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload is only meaningful under its valid bit, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (RESETN) begin
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign out_addr  = addr_q[rd_ptr_q];
  assign out_data  = data_q[rd_ptr_q];
  assign count     = count_q;

  regfile_wq_lookup #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_lookup (
    .ent_addr    (addr_q),
    .ent_data    (data_q),
    .ent_valid   (valid_q),
    .wr_ptr      (wr_ptr_q),
    .lookup_addr (lookup_addr),
    .hit         (lookup_hit),
    .data        (lookup_data)
  );

endmodule

// File: tb/tb_regfile_write_queue.sv
// Randomized and directed bench for regfile_write_queue against a queue-based reference model.
module tb_regfile_write_queue;
  import regfile_write_queue_pkg::*;

  localparam int AW    = WQ_ADDR_WIDTH;
  localparam int DW    = WQ_DATA_WIDTH;
  localparam int DEPTH = WQ_DEPTH;
  localparam int CW    = WQ_CNT_WIDTH;

  logic          CLK = 1'b0;
  logic          RESETN = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] in_addr = '0, lookup_addr = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, lookup_hit;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data, lookup_data;
  logic [CW-1:0] count;

  always #5 CLK = ~CLK;

  regfile_write_queue dut (
    .CLK         (CLK),
    .RESETN      (RESETN),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_addr     (in_addr),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .lookup_addr (lookup_addr),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .count       (count)
  );

  int     n_chk  = 0;
  int     n_fail = 0;
  bit     known  = 0;
  entry_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, compare against the model, then advance the model at posedge.
  task automatic step(input logic rn, input logic iv, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic ordy, input logic [AW-1:0] la);
    bit            push, pop, hit;
    logic [DW-1:0] ld;
    @(negedge CLK);
    RESETN = rn; in_valid = iv; in_addr = a; in_data = d; out_ready = ordy; lookup_addr = la;
    #1;
    if (known) begin
      hit = 0; ld = '0;
      foreach (q[i]) if (q[i].addr == la) begin hit = 1; ld = q[i].data; end
      chk("in_ready",  32'(in_ready),  32'(q.size() < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("count",     32'(count),     32'(q.size()));
      if (q.size() != 0) begin
        chk("out_addr", 32'(out_addr), 32'(q[0].addr));
        chk("out_data", 32'(out_data), 32'(q[0].data));
      end
      chk("lookup_hit",  32'(lookup_hit),  32'(hit));
      chk("lookup_data", 32'(lookup_data), 32'(ld));
    end
    push = iv && q.size() < DEPTH;
    pop  = ordy && q.size() > 0;
    @(posedge CLK);
    if (!rn) begin
      q.delete();
      known = 1;
    end else if (known) begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(entry_t'{addr: a, data: d});
    end
  endtask

  task automatic idle(input logic ordy, input logic [AW-1:0] la);
    step(1'b1, 1'b0, '0, '0, ordy, la);
  endtask

  task automatic push1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(1'b1, 1'b1, a, d, 1'b0, a);
  endtask

  initial begin
    // Reset then idle
    step(1'b0, 1'b0, '0, '0, 1'b0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0);
    idle(1'b0, 2'd1);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Fill and drain in order
    push1(2'd1, 4'hA); push1(2'd2, 4'hB); push1(2'd3, 4'hC); push1(2'd0, 4'hD);
    #1;
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    idle(1'b0, 2'd3);
    for (int i = 0; i < 5; i++) idle(1'b1, 2'(i));
    #1;
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Full with simultaneous push and pop: pop happens, push waits a cycle
    push1(2'd1, 4'h1); push1(2'd2, 4'h2); push1(2'd3, 4'h3); push1(2'd0, 4'h4);
    step(1'b1, 1'b1, 2'd3, 4'h7, 1'b1, 2'd3);
    #1;
    chk("full_pp_count", 32'(count), 32'd3);
    step(1'b1, 1'b1, 2'd3, 4'h7, 1'b0, 2'd3);
    #1;
    chk("full_pp_accept", 32'(count), 32'd4);
    for (int i = 0; i < 5; i++) idle(1'b1, 2'd3);

    // Youngest-match forwarding, including the head in its pop cycle
    push1(2'd2, 4'h5); push1(2'd2, 4'h9);
    idle(1'b0, 2'd2);
    idle(1'b1, 2'd2);
    idle(1'b1, 2'd2);
    idle(1'b0, 2'd2);
    #1;
    chk("fwd_empty_hit", 32'(lookup_hit), 32'd0);

    // Pointer wrap-around with a continuously ready consumer
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 2'(i), 4'(i + 3), 1'b1, 2'(i));
      #1;
      chk("wrap_cnt_le2", 32'(count <= 2), 32'd1);
    end
    for (int i = 0; i < 3; i++) idle(1'b1, '0);

    // Reset mid-operation discards queued writes and the concurrent push
    push1(2'd1, 4'h6); push1(2'd2, 4'h7); push1(2'd3, 4'h8);
    step(1'b0, 1'b1, 2'd0, 4'hF, 1'b0, 2'd0);
    idle(1'b0, 2'd0);
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0), 1'($urandom), 2'($urandom), 4'($urandom),
           ($urandom_range(0, 2) != 0 ? 1'($urandom) : 1'b0), 2'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
